alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the EX stage of the pipelined CPU. Single-cycle ops are add, sub, and and or. Iterative ops are unsigned multiply and, optionally, unsigned divide/remainder. Operands are captured under a valid/ready handshake, and the result is held until the downstream stage accepts it. Zero_o is a real flag computed from the result, so hazard/stall logic can stall EX on ready_o low.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_mc_if.sv | 25 ++
 rtl/alu_iter_muldiv.sv | 101 ++++++++++
 rtl/alu_mc.sv | 112 +++++++++++
 tb/tb_alu_mc.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Opcode encodings and handshake FSM states shared by the alu_mc slice.
// The DIV state only exists when ALU_DIV_EN is defined.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_MUL = 4'b0100;
    localparam logic [3:0] ALU_DIV = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_REM = 4'b0111;

`ifdef ALU_DIV_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } alu_state_e;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd3
    } alu_state_e;
`endif

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle for alu_mc; signal suffixes are from the ALU's view.
// master = upstream/downstream pipeline side, slave = the ALU.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic [3:0]       ALUCtrl_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] data_o;
    logic             Zero_o;

    modport master (
        output valid_i, data1_i, data2_i, ALUCtrl_i, ready_i,
        input  ready_o, valid_o, data_o, Zero_o
    );

    modport slave (
        input  valid_i, data1_i, data2_i, ALUCtrl_i, ready_i,
        output ready_o, valid_o, data_o, Zero_o
    );
endinterface

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier and (with ALU_DIV_EN) restoring divider.
// The start edge performs step 1 from the raw operands; done marks the cycle whose
// combinational result is the final (WIDTH-th) step, so latency is WIDTH cycles.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 2);

    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
    logic [WIDTH-1:0] acc_src, mcand_src, mplier_src, acc_nx;

    // On start the step reads the operands directly instead of the stale registers
    assign acc_src    = start ? '0 : acc_q;
    assign mcand_src  = start ? a  : mcand_q;
    assign mplier_src = start ? b  : mplier_q;
    assign acc_nx     = acc_src + (mplier_src[0] ? mcand_src : '0);

    assign done = busy && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            cnt      <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            if (start) begin
                busy <= 1'b1;
                cnt  <= '0;
            end else if (busy) begin
                cnt <= cnt + CNT_W'(1);
                if (cnt == LAST) busy <= 1'b0;
            end
            if (start || busy) begin
                acc_q    <= acc_nx;
                mcand_q  <= mcand_src << 1;
                mplier_q <= mplier_src >> 1;
            end
        end
    end

`ifdef ALU_DIV_EN
    logic             div_q, rem_q;
    logic [WIDTH-1:0] part_q, quo_q, dvsr_q;
    logic [WIDTH-1:0] part_src, quo_src, dvsr_src, part_nx, quo_nx;
    logic [WIDTH:0]   trial;
    logic             ge;

    assign part_src = start ? '0 : part_q;
    assign quo_src  = start ? a  : quo_q;
    assign dvsr_src = start ? b  : dvsr_q;

    // A zero divisor always "fits": quotient fills with ones, remainder ends as the dividend
    assign trial   = {part_src, quo_src[WIDTH-1]};
    assign ge      = trial >= {1'b0, dvsr_src};
    assign part_nx = ge ? (trial[WIDTH-1:0] - dvsr_src) : trial[WIDTH-1:0];
    assign quo_nx  = {quo_src[WIDTH-2:0], ge};

    assign result = rem_q ? part_nx : (div_q ? quo_nx : acc_nx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= 1'b0;
            rem_q  <= 1'b0;
            part_q <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
        end else begin
            if (start) begin
                div_q <= (op == ALU_DIV);
                rem_q <= (op == ALU_REM);
            end
            if (start || busy) begin
                part_q <= part_nx;
                quo_q  <= quo_nx;
                dvsr_q <= dvsr_src;
            end
        end
    end
`else
    logic unused_op;
    assign unused_op = ^op;
    assign result    = acc_nx;
`endif

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: handshake FSM, single-cycle datapath and result registers.
// Define ALU_DIV_EN to build in the iterative divide/remainder path.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic      clk_i,
    input logic      rst_i,
    alu_mc_if.slave  bus
);
    alu_state_e       state_q, state_d;
    logic             accept, it_start, it_done, load;
    logic [WIDTH-1:0] it_result, load_val, data_q;
    logic             zero_q;

    assign accept = bus.valid_i && (state_q == IDLE);

    alu_iter_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk    (clk_i),
        .rst    (rst_i),
        .start  (it_start),
        .op     (bus.ALUCtrl_i),
        .a      (bus.data1_i),
        .b      (bus.data2_i),
        .done   (it_done),
        .result (it_result)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = '0;
        it_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = DONE;
                    load    = 1'b1;
                    case (bus.ALUCtrl_i)
                        ALU_ADD: load_val = bus.data1_i + bus.data2_i;
                        ALU_SUB: load_val = bus.data1_i - bus.data2_i;
                        ALU_AND: load_val = bus.data1_i & bus.data2_i;
                        ALU_OR:  load_val = bus.data1_i | bus.data2_i;
                        ALU_MUL: begin
                            load     = 1'b0;
                            it_start = 1'b1;
                            state_d  = MUL;
                        end
`ifdef ALU_DIV_EN
                        ALU_DIV, ALU_REM: begin
                            load     = 1'b0;
                            it_start = 1'b1;
                            state_d  = DIV;
                        end
`else
                        // Without the divider these fall through as unknown opcodes
                        ALU_DIV, ALU_REM: load_val = '0;
`endif
                        default: load_val = '0;
                    endcase
                end
            end
            MUL: begin
                if (it_done) begin
                    load     = 1'b1;
                    load_val = it_result;
                    state_d  = DONE;
                end
            end
`ifdef ALU_DIV_EN
            DIV: begin
                if (it_done) begin
                    load     = 1'b1;
                    load_val = it_result;
                    state_d  = DONE;
                end
            end
`endif
            DONE: begin
                if (bus.ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Zero flag is registered alongside the result so it never glitches with inputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
            zero_q <= 1'b0;
        end else if (load) begin
            data_q <= load_val;
            zero_q <= (load_val == '0);
        end
    end

    assign bus.ready_o = (state_q == IDLE);
    assign bus.valid_o = (state_q == DONE);
    assign bus.data_o  = data_q;
    assign bus.Zero_o  = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed and random ops against an arithmetic reference.
// Honours ALU_DIV_EN the same way as the design.
module tb_alu_mc;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    function automatic logic [W-1:0] model_res(input logic [3:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        case (op)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0100: begin
                prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                return prod[W-1:0];
            end
`ifdef ALU_DIV_EN
            4'b0101: return (b == '0) ? {W{1'b1}} : a / b;
            4'b0111: return (b == '0) ? a : a % b;
`endif
            default: return '0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op);
        if (op == 4'b0100) return W;
`ifdef ALU_DIV_EN
        if (op == 4'b0101 || op == 4'b0111) return W;
`endif
        return 1;
    endfunction

    // Issue one op, scramble inputs after accept, wait (bounded) for valid_o.
    // lat counts cycles from the accept cycle to the first cycle with valid_o high.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output logic z, output int lat,
                          output bit rdy_seen);
        int guard = 0;
        rdy_seen = 1'b0;
        while (bus.ready_o !== 1'b1 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.valid_i   = 1'b1;
        bus.data1_i   = a;
        bus.data2_i   = b;
        bus.ALUCtrl_i = op;
        @(posedge clk); #1;
        bus.valid_i   = 1'b0;
        bus.data1_i   = W'($urandom);
        bus.data2_i   = W'($urandom);
        bus.ALUCtrl_i = 4'($urandom);
        lat = 1;
        while (bus.valid_o !== 1'b1 && lat < 200) begin
            if (bus.ready_o !== 1'b0) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        res = bus.data_o;
        z   = bus.Zero_o;
    endtask

    task automatic release_op();
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        bus.ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_vec++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.data_o !== '0 || bus.Zero_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset: got rdy=%b vld=%b data=%h z=%b, expected rdy=1 vld=0 data=0 z=0",
                     bus.ready_o, bus.valid_o, bus.data_o, bus.Zero_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_add_sub();
        logic [3:0]   ops[4] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001};
        logic [3:0]   op;
        logic [W-1:0] a, b, res, exp;
        logic         z;
        int           lat;
        bit           rdy;
        for (int i = 0; i < 22; i++) begin
            if (i == 0) begin op = 4'b0010; a = 5; b = 7; exp = 32'd12; end
            else if (i == 1) begin op = 4'b0110; a = 0; b = 1; exp = 32'hFFFF_FFFF; end
            else begin
                op = ops[$urandom_range(0, 3)];
                a = W'($urandom); b = W'($urandom);
                exp = model_res(op, a, b);
            end
            run_op(op, a, b, res, z, lat, rdy);
            n_vec++;
            if (res !== exp || z !== (exp == '0) || lat != 1) begin
                n_err++;
                $display("FAIL alu op%b #%0d: got data=%h z=%b lat=%0d, expected data=%h z=%b lat=1",
                         op, i, res, z, lat, exp, (exp == '0));
            end
            release_op();
        end
    endtask

    task automatic test_zero();
        logic [3:0]   op;
        logic [W-1:0] a, b, res;
        logic         z;
        int           lat;
        bit           rdy;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin op = 4'b0110; a = 9; b = 9; end
            else if (i == 1) begin op = 4'b1111; a = 32'h1234; b = 32'h55; end
            else begin op = 4'b1000 | 4'($urandom_range(0, 7)); a = W'($urandom); b = W'($urandom); end
            run_op(op, a, b, res, z, lat, rdy);
            n_vec++;
            if (res !== '0 || z !== 1'b1 || lat != 1) begin
                n_err++;
                $display("FAIL zero op%b: got data=%h z=%b lat=%0d, expected data=0 z=1 lat=1",
                         op, res, z, lat);
            end
            release_op();
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] a, b, res, exp;
        logic         z;
        int           lat;
        bit           rdy;
        for (int i = 0; i < 7; i++) begin
            if (i == 0) begin a = 32'h1234_5678; b = 3; exp = 32'h369D_0368; end
            else if (i == 1) begin a = 32'h1_0000; b = 32'h1_0000; exp = '0; end
            else begin a = W'($urandom); b = W'($urandom); exp = model_res(4'b0100, a, b); end
            // ready_i held high while busy must not disturb the op
            if (i >= 2) bus.ready_i = 1'b1;
            run_op(4'b0100, a, b, res, z, lat, rdy);
            n_vec++;
            if (res !== exp || z !== (exp == '0) || lat != W || rdy) begin
                n_err++;
                $display("FAIL mul #%0d: got data=%h z=%b lat=%0d rdy_hi=%b, expected data=%h z=%b lat=%0d rdy_hi=0",
                         i, res, z, lat, rdy, exp, (exp == '0), W);
            end
            release_op();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b, res, exp;
        logic         z;
        int           lat;
        bit           rdy;
        a = W'($urandom); b = W'($urandom);
        exp = a + b;
        run_op(4'b0010, a, b, res, z, lat, rdy);
        n_vec++;
        if (res !== exp) begin
            n_err++;
            $display("FAIL bp result: got %h expected %h", res, exp);
        end
        for (int i = 0; i < 5; i++) begin
            bus.valid_i   = 1'b1;
            bus.data1_i   = W'($urandom);
            bus.ALUCtrl_i = 4'b0001;
            @(posedge clk); #1;
            n_vec++;
            if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0 || bus.data_o !== exp) begin
                n_err++;
                $display("FAIL bp hold %0d: got vld=%b rdy=%b data=%h, expected vld=1 rdy=0 data=%h",
                         i, bus.valid_o, bus.ready_o, bus.data_o, exp);
            end
        end
        bus.valid_i = 1'b0;
        release_op();
        n_vec++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.data_o !== exp) begin
            n_err++;
            $display("FAIL bp release: got rdy=%b vld=%b data=%h, expected rdy=1 vld=0 data=%h",
                     bus.ready_o, bus.valid_o, bus.data_o, exp);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] res;
        logic         z;
        int           lat;
        bit           rdy;
        run_op(4'b0010, 5, 7, res, z, lat, rdy);
        release_op();
        bus.valid_i   = 1'b1;
        bus.data1_i   = 32'hDEAD_BEEF;
        bus.data2_i   = 32'h0000_0007;
        bus.ALUCtrl_i = 4'b0100;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.valid_o !== 1'b0 || bus.data_o !== '0 || bus.ready_o !== 1'b1 || bus.Zero_o !== 1'b0) begin
            n_err++;
            $display("FAIL mid reset: got vld=%b data=%h rdy=%b z=%b, expected vld=0 data=0 rdy=1 z=0",
                     bus.valid_o, bus.data_o, bus.ready_o, bus.Zero_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(4'b0010, 32'd40, 32'd2, res, z, lat, rdy);
        n_vec++;
        if (res !== 32'd42 || z !== 1'b0 || lat != 1) begin
            n_err++;
            $display("FAIL post reset add: got data=%h z=%b lat=%0d, expected data=2a z=0 lat=1",
                     res, z, lat);
        end
        release_op();
    endtask

    task automatic test_div();
        logic [3:0]   ops[4] = '{4'b0101, 4'b0111, 4'b0101, 4'b0111};
        logic [W-1:0] as[4]  = '{32'd100, 32'd100, 32'd5, 32'd5};
        logic [W-1:0] bs[4]  = '{32'd7, 32'd7, 32'd0, 32'd0};
`ifdef ALU_DIV_EN
        logic [W-1:0] exps[4] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5};
        int           elat = W;
`else
        logic [W-1:0] exps[4] = '{32'd0, 32'd0, 32'd0, 32'd0};
        int           elat = 1;
`endif
        logic [W-1:0] res;
        logic         z;
        int           lat;
        bit           rdy;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], res, z, lat, rdy);
            n_vec++;
            if (res !== exps[i] || z !== (exps[i] == '0) || lat != elat) begin
                n_err++;
                $display("FAIL div #%0d op%b: got data=%h z=%b lat=%0d, expected data=%h z=%b lat=%0d",
                         i, ops[i], res, z, lat, exps[i], (exps[i] == '0), elat);
            end
            release_op();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]   ops[7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0111};
        logic [3:0]   op;
        logic [W-1:0] a, b, res, exp;
        logic         z;
        int           lat;
        bit           rdy;
        for (int i = 0; i < 30; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom) : ops[$urandom_range(0, 6)];
            a  = W'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
            exp = model_res(op, a, b);
            run_op(op, a, b, res, z, lat, rdy);
            n_vec++;
            if (res !== exp || z !== (exp == '0) || lat != model_lat(op)) begin
                n_err++;
                $display("FAIL b2b #%0d op%b a=%h b=%h: got data=%h z=%b lat=%0d, expected data=%h z=%b lat=%0d",
                         i, op, a, b, res, z, lat, exp, (exp == '0), model_lat(op));
            end
            release_op();
            n_vec++;
            if (bus.ready_o !== 1'b1) begin
                n_err++;
                $display("FAIL b2b idle #%0d: got ready_o=%b expected 1", i, bus.ready_o);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.valid_i   = 1'b0;
        bus.ready_i   = 1'b0;
        bus.data1_i   = '0;
        bus.data2_i   = '0;
        bus.ALUCtrl_i = '0;
        rst           = 1'b1;
        test_reset();
        test_add_sub();
        test_zero();
        test_mul();
        test_backpressure();
        test_reset_mid_op();
        test_div();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
